// File: rtl/axi_wr_burst_mst.sv
// rtl/axi_wr_burst_mst.sv - AXI write-burst master: linear request plus data stream to AXI write bursts
//
// Turns one (start address, byte count) request plus an input beat stream into
// AXI write bursts. Bursts are split at MAX_BURST beats and at 4KB boundaries.
// The last beat carries tail strobes, and at most MAX_OUTS bursts are in flight.
//
// Ports:
//   clk, rstj                      clock, asynchronous active-low reset
//   cfgStart/cfgAddr/cfgBytes      request (sampled in IDLE only)
//   busy, done, errResp            status (done is a 1-cycle pulse, errResp sticky)
//   inValid/inReady/inData         input beat stream
//   awValid/awReady/awAddr/awLen/awId   AXI write address channel
//   wValid/wReady/wData/wStrb/wLast     AXI write data channel
//   bValid/bResp/bReady                 AXI write response channel
module axi_wr_burst_mst #(
    parameter int         DATA_W    = 128,
    parameter int         ADDR_W    = 32,
    parameter int         LEN_W     = 24,
    parameter int         MAX_BURST = 16,
    parameter int         MAX_OUTS  = 4,
    parameter logic [3:0] AXI_ID    = 4'd0
) (
    input  logic                clk,
    input  logic                rstj,
    input  logic                cfgStart,
    input  logic [ADDR_W-1:0]   cfgAddr,
    input  logic [LEN_W-1:0]    cfgBytes,
    output logic                busy,
    output logic                done,
    output logic                errResp,
    input  logic                inValid,
    output logic                inReady,
    input  logic [DATA_W-1:0]   inData,
    output logic                awValid,
    input  logic                awReady,
    output logic [ADDR_W-1:0]   awAddr,
    output logic [7:0]          awLen,
    output logic [3:0]          awId,
    output logic                wValid,
    input  logic                wReady,
    output logic [DATA_W-1:0]   wData,
    output logic [DATA_W/8-1:0] wStrb,
    output logic                wLast,
    input  logic                bValid,
    input  logic [1:0]          bResp,
    output logic                bReady
);

    localparam int BPB     = DATA_W / 8;
    localparam int BPB_LOG = $clog2(BPB);
    localparam int OUTS_W  = $clog2(MAX_OUTS + 1);
    localparam int PTR_W   = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    aw_left;
    logic [LEN_W-1:0]    w_left;
    logic [LEN_W-1:0]    w_left_nxt;
    logic [BPB_LOG-1:0]  tail;
    logic [OUTS_W-1:0]   outs;
    logic [OUTS_W-1:0]   outs_nxt;
    logic [7:0]          len_mem [MAX_OUTS];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [OUTS_W-1:0]   fifo_cnt;
    logic [7:0]          beat_cnt;

    logic                start_acc, aw_fire, b_fire, w_fire, pending, pop, can_issue;
    logic [LEN_W:0]      bytes_rnd;
    logic [LEN_W-1:0]    beats;
    logic [12:0]         to_4k_bytes;
    logic [12:0]         to_4k_beats;
    logic [LEN_W-1:0]    burst_len;
    logic [BPB-1:0]      tail_mask;

    assign awId    = AXI_ID;
    assign bReady  = 1'b1;
    assign wData   = inData;

    assign start_acc = (state == S_IDLE) && cfgStart;
    assign aw_fire   = awValid && awReady;
    // B beats with nothing outstanding would be protocol errors; ignore them so the count cannot wrap.
    assign b_fire    = bValid && (outs != '0);
    assign pending   = (fifo_cnt != '0);
    assign wValid    = inValid && pending;
    assign inReady   = wReady && pending;
    assign w_fire    = inValid && inReady;
    assign wLast     = pending && (beat_cnt == len_mem[rd_ptr]);
    assign pop       = w_fire && wLast;

    assign bytes_rnd = {1'b0, cfgBytes} + (LEN_W+1)'(BPB - 1);
    assign beats     = LEN_W'(bytes_rnd >> BPB_LOG);

    // Beats left before the next 4KB page; cur_addr is always beat-aligned.
    assign to_4k_bytes = 13'h1000 - {1'b0, cur_addr[11:0]};
    assign to_4k_beats = to_4k_bytes >> BPB_LOG;

    always_comb begin
        burst_len = aw_left;
        if (burst_len > LEN_W'(MAX_BURST))
            burst_len = LEN_W'(MAX_BURST);
        if (burst_len > LEN_W'(to_4k_beats))
            burst_len = LEN_W'(to_4k_beats);
    end

    // A new AW is prepared only while none is waiting for awReady, so awAddr/awLen hold steady.
    assign can_issue = (state == S_RUN) && !awValid && (aw_left != '0) &&
                       (outs < OUTS_W'(MAX_OUTS));

    always_comb begin
        tail_mask = '0;
        for (int i = 0; i < BPB; i++)
            tail_mask[i] = (i < int'(tail));
    end

    assign wStrb = ((w_left == LEN_W'(1)) && (tail != '0)) ? tail_mask : '1;

    always_comb begin
        outs_nxt = outs;
        if (aw_fire && !b_fire)
            outs_nxt = outs + OUTS_W'(1);
        else if (!aw_fire && b_fire)
            outs_nxt = outs - OUTS_W'(1);
    end

    assign w_left_nxt = w_fire ? (w_left - LEN_W'(1)) : w_left;

    always_ff @(posedge clk or negedge rstj) begin
        if (!rstj)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_FIN);
        case (state)
            S_IDLE:  if (cfgStart) state_nxt = (cfgBytes == '0) ? S_FIN : S_RUN;
            S_RUN:   if (aw_fire && (aw_left == '0)) state_nxt = S_DRAIN;
            // Look at next-cycle counts so done follows the final B by one cycle.
            S_DRAIN: if ((w_left_nxt == '0) && (outs_nxt == '0)) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstj) begin
        if (!rstj) begin
            cur_addr <= '0;
            aw_left  <= '0;
            w_left   <= '0;
            tail     <= '0;
            errResp  <= 1'b0;
            awValid  <= 1'b0;
            awAddr   <= '0;
            awLen    <= '0;
            beat_cnt <= '0;
        end else if (start_acc) begin
            cur_addr <= cfgAddr;
            aw_left  <= beats;
            w_left   <= beats;
            tail     <= cfgBytes[BPB_LOG-1:0];
            errResp  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (can_issue) begin
                awValid  <= 1'b1;
                awAddr   <= cur_addr;
                awLen    <= 8'(burst_len - LEN_W'(1));
                cur_addr <= cur_addr + (ADDR_W'(burst_len) << BPB_LOG);
                aw_left  <= aw_left - burst_len;
            end else if (aw_fire) begin
                awValid  <= 1'b0;
            end
            if (w_fire) begin
                w_left   <= w_left - LEN_W'(1);
                beat_cnt <= wLast ? 8'd0 : beat_cnt + 8'd1;
            end
            if (b_fire && (bResp != 2'b00))
                errResp <= 1'b1;
        end
    end

    // Burst-length FIFO: one entry per accepted AW, popped by that burst's last W beat.
    always_ff @(posedge clk or negedge rstj) begin
        if (!rstj) begin
            outs     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            outs <= outs_nxt;
            if (aw_fire)
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTS - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTS - 1)) ? '0 : rd_ptr + PTR_W'(1);
            if (aw_fire && !pop)
                fifo_cnt <= fifo_cnt + OUTS_W'(1);
            else if (!aw_fire && pop)
                fifo_cnt <= fifo_cnt - OUTS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (aw_fire)
            len_mem[wr_ptr] <= awLen;
    end

endmodule

// File: tb/tb_axi_wr_burst_mst.sv
// tb/tb_axi_wr_burst_mst.sv - directed self-checking bench for axi_wr_burst_mst
module tb_axi_wr_burst_mst;

    logic         clk = 1'b0;
    logic         rstj = 1'b0;
    logic         cfgStart = 1'b0;
    logic [31:0]  cfgAddr = '0;
    logic [23:0]  cfgBytes = '0;
    logic         busy, done, errResp;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [127:0] inData = '0;
    logic         awValid;
    logic         awReady = 1'b0;
    logic [31:0]  awAddr;
    logic [7:0]   awLen;
    logic [3:0]   awId;
    logic         wValid;
    logic         wReady = 1'b0;
    logic [127:0] wData;
    logic [15:0]  wStrb;
    logic         wLast;
    logic         bValid = 1'b0;
    logic [1:0]   bResp = 2'b00;
    logic         bReady;

    always #5 clk = ~clk;

    axi_wr_burst_mst #(
        .DATA_W(128), .ADDR_W(32), .LEN_W(24),
        .MAX_BURST(16), .MAX_OUTS(4), .AXI_ID(4'h5)
    ) dut (
        .clk(clk), .rstj(rstj),
        .cfgStart(cfgStart), .cfgAddr(cfgAddr), .cfgBytes(cfgBytes),
        .busy(busy), .done(done), .errResp(errResp),
        .inValid(inValid), .inReady(inReady), .inData(inData),
        .awValid(awValid), .awReady(awReady), .awAddr(awAddr), .awLen(awLen), .awId(awId),
        .wValid(wValid), .wReady(wReady), .wData(wData), .wStrb(wStrb), .wLast(wLast),
        .bValid(bValid), .bResp(bResp), .bReady(bReady)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(i);
        return {w, ~w, w ^ 32'h5A5A5A5A, w + 32'h11111111};
    endfunction

    // Bench-side bookkeeping, shared between the driver, the sampler and the tests.
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    int          cyc = 0;
    int          w_idx, in_idx, w_in_burst, w_burst, tot_beats, tail;
    int          b_pending, b_num, err_burst;
    int          start_cyc, done_cyc, last_b_cyc, first_awv_cyc;
    bit          done_seen, rnd, b_en;
    bit          aw_hold;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;
    logic [15:0] exp_strb, last_strb;
    bit          exp_last;

    task automatic clear_book();
        aw_addr_q.delete();
        aw_len_q.delete();
        w_idx = 0; in_idx = 0; w_in_burst = 0; w_burst = 0;
        tot_beats = 0; tail = 0; b_pending = 0; b_num = 0; err_burst = -1;
        start_cyc = -1; done_cyc = -1; last_b_cyc = -1; first_awv_cyc = -1;
        done_seen = 0; aw_hold = 0; last_strb = '0;
    endtask

    // Input/slave driver: drives on the falling edge.
    always @(negedge clk) begin
        awReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        wReady  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        inValid = (in_idx < tot_beats) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        inData  = pat(in_idx);
        if (b_en && b_pending > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
            bValid = 1'b1;
            bResp  = (b_num == err_burst) ? 2'd2 : 2'd0;
        end else begin
            bValid = 1'b0;
            bResp  = 2'd0;
        end
    end

    // Sampler: observes handshakes just before the rising edge.
    always @(negedge clk) begin
        #4;
        cyc++;
        if (rstj) begin
            if (cfgStart) start_cyc = cyc;
            if (awValid && first_awv_cyc < 0) first_awv_cyc = cyc;
            if (aw_hold) begin
                chk("aw_stable_addr", awAddr, hold_addr);
                chk("aw_stable_len", awLen, hold_len);
            end
            aw_hold   = awValid && !awReady;
            hold_addr = awAddr;
            hold_len  = awLen;
            if (awValid && awReady) begin
                aw_addr_q.push_back(awAddr);
                aw_len_q.push_back(awLen);
                chk("awid", awId, 4'h5);
            end
            if (wValid && wReady) begin
                chk("w_after_aw", w_burst < aw_len_q.size(), 1);
                chk("wdata_order", wData, pat(w_idx));
                exp_strb = (w_idx == tot_beats - 1 && tail != 0) ? 16'((1 << tail) - 1) : 16'hFFFF;
                chk("wstrb", wStrb, exp_strb);
                exp_last = (w_burst < aw_len_q.size()) && (w_in_burst == int'(aw_len_q[w_burst]));
                chk("wlast", wLast, exp_last);
                last_strb = wStrb;
                if (wLast) begin
                    w_burst++;
                    w_in_burst = 0;
                    b_pending++;
                end else begin
                    w_in_burst++;
                end
                w_idx++;
            end
            if (inValid && inReady) in_idx++;
            if (bValid && bReady) begin
                b_pending--;
                b_num++;
                last_b_cyc = cyc;
            end
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
        end
    end

    // Called right after a falling edge; leaves the caller at +4 of the next one.
    task automatic start_xfer(input logic [31:0] addr, input int bytes, input bit r, input int eb);
        clear_book();
        tot_beats = (bytes + 15) / 16;
        tail      = bytes % 16;
        err_burst = eb;
        rnd       = r;
        cfgAddr   = addr;
        cfgBytes  = 24'(bytes);
        cfgStart  = 1'b1;
        @(negedge clk);
        cfgStart  = 1'b0;
        #4;
        chk("busy_after_start", busy, 1);
        chk("err_clr_on_start", errResp, 0);
    endtask

    task automatic wait_done(input int tmo);
        for (int i = 0; i < tmo && !done_seen; i++) begin
            @(negedge clk);
            #6;
        end
        chk("done_seen", done_seen, 1);
        @(negedge clk);
    endtask

    task automatic run_xfer(input logic [31:0] addr, input int bytes, input bit r, input int eb);
        start_xfer(addr, bytes, r, eb);
        wait_done(3000);
        chk("beats_total", w_idx, (bytes + 15) / 16);
        if (bytes > 0) begin
            chk("aw_latency", first_awv_cyc - start_cyc, 2);
            chk("done_after_b", done_cyc - last_b_cyc, 1);
        end
    endtask

    initial begin
        clear_book();
        rnd = 0;
        b_en = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", errResp, 0);
        chk("rst_awvalid", awValid, 0);
        chk("rst_wvalid", wValid, 0);
        chk("rst_inready", inReady, 0);
        chk("rst_awaddr", awAddr, 0);
        chk("rst_awlen", awLen, 0);
        @(negedge clk);
        rstj = 1'b1;
        @(negedge clk);

        // Single burst.
        run_xfer(32'h1000, 64, 0, -1);
        chk("t1_aw_count", aw_addr_q.size(), 1);
        chk("t1_aw_addr", aw_addr_q[0], 32'h1000);
        chk("t1_aw_len", aw_len_q[0], 8'd3);
        chk("t1_err", errResp, 0);

        // 4KB boundary split.
        run_xfer(32'h1FC0, 256, 0, -1);
        chk("t2_aw_count", aw_addr_q.size(), 2);
        chk("t2_aw0_addr", aw_addr_q[0], 32'h1FC0);
        chk("t2_aw0_len", aw_len_q[0], 8'd3);
        chk("t2_aw1_addr", aw_addr_q[1], 32'h2000);
        chk("t2_aw1_len", aw_len_q[1], 8'd11);
        chk("t2_err", errResp, 0);

        // Zero-length request.
        start_xfer(32'h0, 0, 0, -1);
        wait_done(10);
        chk("t4_zero_lat", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);
        chk("t4_no_aw", aw_addr_q.size(), 0);
        chk("t4_no_w", w_idx, 0);

        // Outstanding limit with B withheld.
        b_en = 0;
        start_xfer(32'h0, 2048, 0, -1);
        repeat (150) @(negedge clk);
        #4;
        chk("t5_aw_held_count", aw_addr_q.size(), 4);
        chk("t5_awvalid_low", awValid, 0);
        chk("t5_beats_held", w_idx, 64);
        for (int i = 0; i < 4; i++)
            chk("t5_aw_len", aw_len_q[i], 8'd15);
        b_en = 1;
        wait_done(3000);
        chk("t5_aw_count", aw_addr_q.size(), 8);
        chk("t5_beats", w_idx, 128);
        chk("t5_aw7_addr", aw_addr_q[7], 32'h700);

        // Random stalls and one SLVERR response.
        run_xfer(32'h3000, 512, 1, 1);
        chk("t6_aw_count", aw_addr_q.size(), 2);
        chk("t6_err_set", errResp, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("t6_err_sticky", errResp, 1);
        @(negedge clk);

        // Tail strobes; also clears errResp on start.
        run_xfer(32'h0, 40, 0, -1);
        chk("t3_last_strb", last_strb, 16'h00FF);
        chk("t3_aw_len", aw_len_q[0], 8'd2);

        // Ignored start while busy.
        b_en = 0;
        start_xfer(32'h0, 64, 0, -1);
        cfgAddr = 32'h8000;
        cfgBytes = 24'd16;
        cfgStart = 1'b1;
        @(negedge clk);
        cfgStart = 1'b0;
        b_en = 1;
        wait_done(500);
        chk("t7_aw_count", aw_addr_q.size(), 1);
        chk("t7_beats", w_idx, 4);

        // Asynchronous reset mid-transfer.
        start_xfer(32'h0, 512, 1, -1);
        repeat (20) @(negedge clk);
        #2;
        rstj = 1'b0;
        #1;
        chk("t8_rst_busy", busy, 0);
        chk("t8_rst_awvalid", awValid, 0);
        chk("t8_rst_wvalid", wValid, 0);
        chk("t8_rst_inready", inReady, 0);
        chk("t8_rst_awaddr", awAddr, 0);
        chk("t8_rst_awlen", awLen, 0);
        chk("t8_rst_done", done, 0);
        b_en = 0;
        @(negedge clk);
        rnd = 0;
        clear_book();
        rstj = 1'b1;
        b_en = 1;
        @(negedge clk);
        run_xfer(32'h1000, 64, 0, -1);
        chk("t8_aw_count", aw_addr_q.size(), 1);
        chk("t8_aw_addr", aw_addr_q[0], 32'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
